// File: rtl/sisc_exec_ctrl.sv
// sisc_exec_ctrl: multi-cycle control FSM, 32-bit ALU with {C,N,V,Z} status
// and branch-target adder for the SISC processor.
module sisc_exec_ctrl (
   input  logic        clk,
   input  logic        rst_f,
   input  logic [31:0] instr,
   input  logic [31:0] rega,
   input  logic [31:0] regb,
   input  logic [3:0]  stat,
   input  logic [15:0] pc_out,
   output logic [31:0] alu_out,
   output logic [3:0]  alu_sts,
   output logic        stat_en,
   output logic [15:0] br_addr,
   output logic        rf_we,
   output logic        wb_sel,
   output logic        rb_sel,
   output logic        br_sel,
   output logic        pc_rst,
   output logic        pc_write,
   output logic        pc_sel,
   output logic        ir_load,
   output logic [1:0]  alu_op
);
   typedef enum logic [2:0] {
      START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT
   } state_t;

   localparam logic [3:0] OP_REG = 4'h1;
   localparam logic [3:0] OP_IMM = 4'h2;
   localparam logic [3:0] OP_BRA = 4'h4;
   localparam logic [3:0] OP_BRR = 4'h5;
   localparam logic [3:0] OP_BNE = 4'h6;
   localparam logic [3:0] OP_BNR = 4'h7;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [3:0] F_ADD = 4'h1;
   localparam logic [3:0] F_SUB = 4'h2;
   localparam logic [3:0] F_NOT = 4'h3;
   localparam logic [3:0] F_OR  = 4'h4;
   localparam logic [3:0] F_AND = 4'h5;
   localparam logic [3:0] F_XOR = 4'h6;
   localparam logic [3:0] F_SHL = 4'h7;
   localparam logic [3:0] F_SHR = 4'h8;
   localparam logic [3:0] F_ROL = 4'h9;
   localparam logic [3:0] F_ROR = 4'hA;

   state_t      state_q, state_d;
   logic [3:0]  opcode, mm;
   logic        is_reg, is_pos_br, is_neg_br, cond_hit, br_taken, br_rel;
   logic [1:0]  reg_alu_op;

   assign opcode     = instr[31:28];
   assign mm         = instr[27:24];
   assign is_reg     = (opcode == OP_REG) || (opcode == OP_IMM);
   assign reg_alu_op = (opcode == OP_IMM) ? 2'b01 : 2'b00;
   assign is_pos_br  = (opcode == OP_BRA) || (opcode == OP_BRR);
   assign is_neg_br  = (opcode == OP_BNE) || (opcode == OP_BNR);
   assign br_rel     = (opcode == OP_BRR) || (opcode == OP_BNR);
   assign cond_hit   = |(mm & stat);
   assign br_taken   = (is_pos_br && ((mm == 4'h0) || cond_hit)) ||
                       (is_neg_br && (mm != 4'h0) && !cond_hit);

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) state_q <= START0;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      pc_rst   = 1'b0;
      ir_load  = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
      rf_we    = 1'b0;
      stat_en  = 1'b0;
      alu_op   = 2'b00;
      case (state_q)
         START0: begin
            pc_rst  = 1'b1;
            state_d = START1;
         end
         START1: state_d = FETCH;
         FETCH: begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
            state_d  = DECODE;
         end
         DECODE: begin
            pc_write = br_taken;
            pc_sel   = br_taken;
            br_sel   = br_taken && br_rel;
            state_d  = (opcode == OP_HLT) ? HALT : EXECUTE;
         end
         EXECUTE: begin
            alu_op  = is_reg ? reg_alu_op : 2'b00;
            stat_en = is_reg;
            state_d = MEM;
         end
         MEM: begin
            alu_op  = is_reg ? reg_alu_op : 2'b00;
            state_d = WRITEBACK;
         end
         WRITEBACK: begin
            alu_op  = is_reg ? reg_alu_op : 2'b00;
            rf_we   = is_reg;
            state_d = FETCH;
         end
         HALT:    state_d = HALT;
         default: state_d = START0;
      endcase
   end

   assign rb_sel = 1'b0;
   assign wb_sel = 1'b0;

   logic [31:0] op_b;
   logic [32:0] add_r, sub_r;
   logic [63:0] rol_w, ror_w;
   logic [4:0]  sh;
   logic        c_flag, v_flag;

   // Reserved alu_op codes fall back to regb.
   assign op_b  = (alu_op == 2'b01) ? {{16{instr[15]}}, instr[15:0]} : regb;
   assign sh    = op_b[4:0];
   assign add_r = {1'b0, rega} + {1'b0, op_b};
   assign sub_r = {1'b0, rega} + {1'b0, ~op_b} + 33'd1;
   assign rol_w = {rega, rega} << sh;
   assign ror_w = {rega, rega} >> sh;

   always_comb begin
      alu_out = rega;
      c_flag  = 1'b0;
      v_flag  = 1'b0;
      case (instr[27:24])
         F_ADD: begin
            alu_out = add_r[31:0];
            c_flag  = add_r[32];
            v_flag  = (rega[31] == op_b[31]) && (add_r[31] != rega[31]);
         end
         F_SUB: begin
            alu_out = sub_r[31:0];
            c_flag  = sub_r[32];
            v_flag  = (rega[31] != op_b[31]) && (sub_r[31] != rega[31]);
         end
         F_NOT:   alu_out = ~rega;
         F_OR:    alu_out = rega | op_b;
         F_AND:   alu_out = rega & op_b;
         F_XOR:   alu_out = rega ^ op_b;
         F_SHL:   alu_out = rega << sh;
         F_SHR:   alu_out = rega >> sh;
         F_ROL:   alu_out = rol_w[63:32];
         F_ROR:   alu_out = ror_w[31:0];
         default: alu_out = rega;
      endcase
   end

   assign alu_sts = {c_flag, alu_out[31], v_flag, alu_out == 32'h0};
   assign br_addr = br_sel ? pc_out + instr[15:0] : instr[15:0];

   logic unused_ok;
   assign unused_ok = ^{instr[23:16], rol_w[31:0], ror_w[63:32], op_b[31:5]};
endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// tb_sisc_exec_ctrl: scoreboard bench; a cycle-slot reference model predicts every
// strobe and ALU/branch output, a negedge monitor pops and compares.
module tb_sisc_exec_ctrl;
   logic        clk = 1'b0;
   logic        rst_f = 1'b0;
   logic [31:0] instr = '0, rega = '0, regb = '0;
   logic [3:0]  stat = '0;
   logic [15:0] pc_out = '0;
   logic [31:0] alu_out;
   logic [3:0]  alu_sts;
   logic [15:0] br_addr;
   logic        stat_en, rf_we, wb_sel, rb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load;
   logic [1:0]  alu_op;

   sisc_exec_ctrl dut (
      .clk(clk), .rst_f(rst_f), .instr(instr), .rega(rega), .regb(regb), .stat(stat),
      .pc_out(pc_out), .alu_out(alu_out), .alu_sts(alu_sts), .stat_en(stat_en),
      .br_addr(br_addr), .rf_we(rf_we), .wb_sel(wb_sel), .rb_sel(rb_sel), .br_sel(br_sel),
      .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel), .ir_load(ir_load), .alu_op(alu_op)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        pc_rst, ir_load, pc_write, pc_sel, br_sel, rf_we, stat_en, wb_sel, rb_sel;
      logic [1:0]  alu_op;
      logic [31:0] alu_out;
      logic [3:0]  alu_sts;
      logic [15:0] br_addr;
   } exp_t;

   typedef struct packed {
      logic [31:0] ins, a, b;
      logic [3:0]  st;
      logic [15:0] pc;
   } txn_t;

   exp_t exp_q[$];
   txn_t dir_q[$];
   int   n_chk = 0, n_fail = 0;
   int   k = 0;
   bit   halted = 1'b0, started = 1'b0;

   function automatic logic [35:0] alu_ref(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, sr;
      logic [63:0] u;
      logic [31:0] r;
      logic c, v;
      int sh;
      sa = $signed(a); sb = $signed(b); sh = int'(b[4:0]);
      c = 1'b0; v = 1'b0; r = a;
      case (f)
         4'd1: begin
            u = {32'h0, a} + {32'h0, b}; r = u[31:0]; c = u[32];
            sr = sa + sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'd2: begin
            u = {32'h0, a} + {32'h0, ~b} + 64'd1; r = u[31:0]; c = u[32];
            sr = sa - sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'd3: r = ~a;
         4'd4: r = a | b;
         4'd5: r = a & b;
         4'd6: r = a ^ b;
         4'd7: for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0};
         4'd8: for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]};
         4'd9: for (int i = 0; i < sh; i++) r = {r[30:0], r[31]};
         4'd10: for (int i = 0; i < sh; i++) r = {r[0], r[31:1]};
         default: r = a;
      endcase
      return {c, r[31], v, (r == 32'h0), r};
   endfunction

   // Instruction slot: 0 fetch, 1 decode, 2 execute, 3 mem, 4 writeback.
   function automatic exp_t model();
      exp_t e;
      logic [3:0] op, m;
      logic [35:0] ar;
      logic [31:0] b;
      bit reg_op, hit, taken;
      int s;
      e = '0;
      op = instr[31:28]; m = instr[27:24];
      reg_op = (op == 4'd1) || (op == 4'd2);
      hit = (m & stat) != 4'h0;
      taken = ((op == 4'd4 || op == 4'd5) && (m == 4'h0 || hit)) ||
              ((op == 4'd6 || op == 4'd7) && m != 4'h0 && !hit);
      if (!rst_f || k == 0) e.pc_rst = 1'b1;
      else if (!halted && k >= 2) begin
         s = (k - 2) % 5;
         if (s == 0) begin e.ir_load = 1'b1; e.pc_write = 1'b1; end
         if (s == 1 && taken) begin
            e.pc_write = 1'b1; e.pc_sel = 1'b1; e.br_sel = (op == 4'd5) || (op == 4'd7);
         end
         if (s >= 2 && op == 4'd2) e.alu_op = 2'b01;
         if (s == 2) e.stat_en = reg_op;
         if (s == 4) e.rf_we = reg_op;
      end
      b = (e.alu_op == 2'b01) ? 32'(signed'(instr[15:0])) : regb;
      ar = alu_ref(instr[27:24], rega, b);
      e.alu_out = ar[31:0];
      e.alu_sts = ar[35:32];
      e.br_addr = e.br_sel ? 16'(pc_out + instr[15:0]) : instr[15:0];
      return e;
   endfunction

   task automatic load_next();
      txn_t t;
      logic [3:0] op;
      if (dir_q.size() > 0) t = dir_q.pop_front();
      else begin
         op = 4'($urandom_range(0, 14));
         t.ins = {op, 4'($urandom_range(0, 15)), 8'($urandom), 16'($urandom)};
         t.a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
         t.b = ($urandom_range(0, 3) == 0) ? t.a : $urandom;
         t.st = 4'($urandom);
         t.pc = 16'($urandom);
      end
      instr = t.ins; rega = t.a; regb = t.b; stat = t.st; pc_out = t.pc;
   endtask

   task automatic cycle(input bit rst_now);
      bit dec;
      @(posedge clk);
      #1;
      if (!rst_f) k = 0;
      else k++;
      rst_f = !rst_now;
      if (!rst_f) begin k = 0; halted = 1'b0; end
      dec = rst_f && !halted && k >= 2 && ((k - 2) % 5 == 1);
      if (dec) load_next();
      exp_q.push_back(model());
      started = 1'b1;
      if (dec && instr[31:28] == 4'hF) halted = 1'b1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", nm, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (started) begin
         if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard: got empty queue expected an entry at t=%0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("pc_rst", 32'(pc_rst), 32'(e.pc_rst));
            chk("ir_load", 32'(ir_load), 32'(e.ir_load));
            chk("pc_write", 32'(pc_write), 32'(e.pc_write));
            chk("pc_sel", 32'(pc_sel), 32'(e.pc_sel));
            chk("br_sel", 32'(br_sel), 32'(e.br_sel));
            chk("rf_we", 32'(rf_we), 32'(e.rf_we));
            chk("stat_en", 32'(stat_en), 32'(e.stat_en));
            chk("wb_sel", 32'(wb_sel), 32'(e.wb_sel));
            chk("rb_sel", 32'(rb_sel), 32'(e.rb_sel));
            chk("alu_op", 32'(alu_op), 32'(e.alu_op));
            chk("alu_out", alu_out, e.alu_out);
            chk("alu_sts", 32'(alu_sts), 32'(e.alu_sts));
            chk("br_addr", 32'(br_addr), 32'(e.br_addr));
         end
      end
   end

   initial begin
      repeat (3) cycle(1'b1);
      dir_q.push_back('{ins: 32'h1123_0001, a: 32'h7FFF_FFFF, b: 32'h1, st: 4'h0, pc: 16'h0});
      dir_q.push_back('{ins: 32'h2211_0005, a: 32'h5, b: 32'h1234, st: 4'h0, pc: 16'h0});
      dir_q.push_back('{ins: 32'h4100_0020, a: 32'h0, b: 32'h0, st: 4'h1, pc: 16'h5});
      dir_q.push_back('{ins: 32'h4100_0020, a: 32'h0, b: 32'h0, st: 4'h0, pc: 16'h5});
      dir_q.push_back('{ins: 32'h7100_FFFE, a: 32'h0, b: 32'h0, st: 4'h0, pc: 16'h0010});
      dir_q.push_back('{ins: 32'h2A00_0021, a: 32'h8000_0001, b: 32'h0, st: 4'h0, pc: 16'h0});
      dir_q.push_back('{ins: 32'h1900_0000, a: 32'hDEAD_BEEF, b: 32'h24, st: 4'h0, pc: 16'h0});
      repeat (40) cycle(1'b0);
      repeat (400) cycle(1'b0);
      repeat (2) cycle(1'b1);
      repeat (300) cycle(1'b0);
      dir_q.push_back('{ins: 32'hF000_0000, a: 32'h1, b: 32'h2, st: 4'h0, pc: 16'h0});
      for (int i = 0; i < 20 && !halted; i++) cycle(1'b0);
      repeat (12) cycle(1'b0);
      cycle(1'b1);
      repeat (30) cycle(1'b0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
